// File: rtl/router_one_port.sv
// Single-input mesh router stage: 2-entry FIFO feeding a dimension-order route decoder.
// Define ROUTER_ONE_PORT_YX_ROUTING_EN to resolve Y before X; the default build routes XY.
module router_one_port #(
    parameter int X_COORD    = 0,
    parameter int Y_COORD    = 0,
    parameter int DATA_WIDTH = 32,
    parameter int MESH_SIDE  = 3,
    localparam int CW        = $clog2(MESH_SIDE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CW-1:0]           in_dest_x,
    input  logic [CW-1:0]           in_dest_y,
    input  logic                    in_s_delta_x,
    input  logic                    in_s_delta_y,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [5*DATA_WIDTH-1:0] out_data,
    output logic [5*CW-1:0]         out_dest_x,
    output logic [5*CW-1:0]         out_dest_y,
    output logic [4:0]              out_s_delta_x,
    output logic [4:0]              out_s_delta_y,
    output logic [4:0]              out_valid,
    input  logic [4:0]              out_ready,
    output logic                    valid,
    output logic                    route_out_N,
    output logic                    route_out_E,
    output logic                    route_out_S,
    output logic                    route_out_W,
    output logic                    route_out_L
);

    localparam int FW = DATA_WIDTH + 2 * CW;
    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;
    localparam int DIR_L = 4;
    localparam logic [CW-1:0] LP_X = CW'(X_COORD);
    localparam logic [CW-1:0] LP_Y = CW'(Y_COORD);

    logic [FW-1:0]         r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [FW-1:0]         w_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [CW-1:0]         w_head_dx;
    logic [CW-1:0]         w_head_dy;
    logic [4:0]            w_route_oh;
    logic [4:0]            w_out_valid;
    logic                  w_unused_ok;

    // Upstream sign bits are recomputed locally, so the incoming ones are dropped.
    assign w_unused_ok = in_s_delta_x ^ in_s_delta_y;

    assign in_ready = (r_count < 2'd2);
    assign valid    = (r_count != 2'd0);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = |(w_out_valid & out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; it is only observed when count says it is live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {in_data, in_dest_x, in_dest_y};
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[FW-1 -: DATA_WIDTH];
    assign w_head_dx   = w_head[2*CW-1 -: CW];
    assign w_head_dy   = w_head[CW-1:0];

    always_comb begin
        w_route_oh = 5'b00000;
`ifdef ROUTER_ONE_PORT_YX_ROUTING_EN
        if (w_head_dy > LP_Y)      w_route_oh[DIR_S] = 1'b1;
        else if (w_head_dy < LP_Y) w_route_oh[DIR_N] = 1'b1;
        else if (w_head_dx > LP_X) w_route_oh[DIR_E] = 1'b1;
        else if (w_head_dx < LP_X) w_route_oh[DIR_W] = 1'b1;
        else                       w_route_oh[DIR_L] = 1'b1;
`else
        if (w_head_dx > LP_X)      w_route_oh[DIR_E] = 1'b1;
        else if (w_head_dx < LP_X) w_route_oh[DIR_W] = 1'b1;
        else if (w_head_dy > LP_Y) w_route_oh[DIR_S] = 1'b1;
        else if (w_head_dy < LP_Y) w_route_oh[DIR_N] = 1'b1;
        else                       w_route_oh[DIR_L] = 1'b1;
`endif
    end

    assign w_out_valid   = valid ? w_route_oh : 5'b00000;
    assign out_valid     = w_out_valid;
    assign route_out_N   = w_out_valid[DIR_N];
    assign route_out_E   = w_out_valid[DIR_E];
    assign route_out_S   = w_out_valid[DIR_S];
    assign route_out_W   = w_out_valid[DIR_W];
    assign route_out_L   = w_out_valid[DIR_L];

    // Every direction sees the head flit; consumers qualify with out_valid.
    assign out_data      = {5{w_head_data}};
    assign out_dest_x    = {5{w_head_dx}};
    assign out_dest_y    = {5{w_head_dy}};
    assign out_s_delta_x = {5{w_head_dx < LP_X}};
    assign out_s_delta_y = {5{w_head_dy < LP_Y}};

endmodule

// File: tb/tb_router_one_port.sv
// Directed bench for router_one_port at (1,1) in a 3x3 mesh; a queue models the FIFO contents.
module tb_router_one_port;

    localparam int DW = 32;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic [CW-1:0]   in_dest_x;
    logic [CW-1:0]   in_dest_y;
    logic            in_s_delta_x;
    logic            in_s_delta_y;
    logic            in_valid;
    logic            in_ready;
    logic [5*DW-1:0] out_data;
    logic [5*CW-1:0] out_dest_x;
    logic [5*CW-1:0] out_dest_y;
    logic [4:0]      out_s_delta_x;
    logic [4:0]      out_s_delta_y;
    logic [4:0]      out_valid;
    logic [4:0]      out_ready;
    logic            valid;
    logic            route_out_N;
    logic            route_out_E;
    logic            route_out_S;
    logic            route_out_W;
    logic            route_out_L;

    always #5 clk = ~clk;

    router_one_port #(
        .X_COORD   (1),
        .Y_COORD   (1),
        .DATA_WIDTH(DW),
        .MESH_SIDE (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_dest_x    (in_dest_x),
        .in_dest_y    (in_dest_y),
        .in_s_delta_x (in_s_delta_x),
        .in_s_delta_y (in_s_delta_y),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_dest_x   (out_dest_x),
        .out_dest_y   (out_dest_y),
        .out_s_delta_x(out_s_delta_x),
        .out_s_delta_y(out_s_delta_y),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .valid        (valid),
        .route_out_N  (route_out_N),
        .route_out_E  (route_out_E),
        .route_out_S  (route_out_S),
        .route_out_W  (route_out_W),
        .route_out_L  (route_out_L)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
    } flit_t;

    flit_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Router sits at (1,1): N=bit0, E=bit1, S=bit2, W=bit3, L=bit4.
    function automatic logic [4:0] model_route(input logic [CW-1:0] dx, input logic [CW-1:0] dy);
        logic [4:0] r;
`ifdef ROUTER_ONE_PORT_YX_ROUTING_EN
        if (dy > 2'd1)      r = 5'b00100;
        else if (dy < 2'd1) r = 5'b00001;
        else if (dx > 2'd1) r = 5'b00010;
        else if (dx < 2'd1) r = 5'b01000;
        else                r = 5'b10000;
`else
        if (dx > 2'd1)      r = 5'b00010;
        else if (dx < 2'd1) r = 5'b01000;
        else if (dy > 2'd1) r = 5'b00100;
        else if (dy < 2'd1) r = 5'b00001;
        else                r = 5'b10000;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        flit_t      h;
        logic [4:0] rt;
        logic [4:0] route_vec;
        route_vec = {route_out_L, route_out_W, route_out_S, route_out_E, route_out_N};
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_q.size() < 2));
        chk({tag, ".valid"}, 64'(valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            h  = exp_q[0];
            rt = model_route(h.dx, h.dy);
            chk({tag, ".out_valid"}, 64'(out_valid), 64'(rt));
            chk({tag, ".route_out"}, 64'(route_vec), 64'(rt));
            for (int d = 0; d < 5; d++) begin
                chk({tag, ".out_data"}, 64'(out_data[d*DW +: DW]), 64'(h.data));
                chk({tag, ".out_dest_x"}, 64'(out_dest_x[d*CW +: CW]), 64'(h.dx));
                chk({tag, ".out_dest_y"}, 64'(out_dest_y[d*CW +: CW]), 64'(h.dy));
            end
            chk({tag, ".s_delta_x"}, 64'(out_s_delta_x), 64'({5{h.dx < 2'd1}}));
            chk({tag, ".s_delta_y"}, 64'(out_s_delta_y), 64'({5{h.dy < 2'd1}}));
        end else begin
            chk({tag, ".out_valid_idle"}, 64'(out_valid), 64'(0));
            chk({tag, ".route_out_idle"}, 64'(route_vec), 64'(0));
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] dx,
                         input logic [CW-1:0] dy);
        in_valid  = v;
        in_data   = d;
        in_dest_x = dx;
        in_dest_y = dy;
    endtask

    // Advance one clock: model pop/push at the edge, then check at the falling edge.
    task automatic tick(input string tag);
        bit do_pop;
        bit do_push;
        @(posedge clk);
        do_pop  = (exp_q.size() > 0) &&
                  ((out_ready & model_route(exp_q[0].dx, exp_q[0].dy)) != 5'b00000);
        do_push = in_valid && (exp_q.size() < 2);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{in_data, in_dest_x, in_dest_y});
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst          = 1'b1;
        in_s_delta_x = 1'b0;
        in_s_delta_y = 1'b0;
        out_ready    = 5'b11111;
        drive(1'b0, '0, '0, '0);
        #2 rst = 1'b0;
        #10;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        tick("reset_release");

        // One flit per destination class.
        drive(1'b1, 32'h0000_00E1, 2'd2, 2'd1); tick("route_e");
        drive(1'b0, '0, '0, '0);                tick("route_e_drain");
        drive(1'b1, 32'h0000_00B0, 2'd0, 2'd0); tick("route_w");
        drive(1'b0, '0, '0, '0);                tick("route_w_drain");
        drive(1'b1, 32'h0000_0512, 2'd1, 2'd2); tick("route_s");
        drive(1'b1, 32'h0000_0410, 2'd1, 2'd0); tick("route_n");
        drive(1'b1, 32'h0000_0111, 2'd1, 2'd1); tick("route_l");
        drive(1'b0, '0, '0, '0);                tick("route_l_drain");

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'((i + 1) * 10), 2'(i % 3), 2'((i / 3) % 3));
            tick("stream");
        end
        drive(1'b0, '0, '0, '0);
        tick("stream_drain");

        // EAST blocked: two accepted, third held off until the head drains.
        out_ready = 5'b11101;
        drive(1'b1, 32'h0000_0100, 2'd2, 2'd1); tick("bp_push_a");
        drive(1'b1, 32'h0000_0200, 2'd2, 2'd1); tick("bp_push_b");
        chk("bp_full_in_ready", 64'(in_ready), 64'(0));
        drive(1'b1, 32'h0000_0300, 2'd2, 2'd1); tick("bp_hold_1");
        tick("bp_hold_2");
        out_ready = 5'b11111;
        tick("bp_pop_a");
        tick("bp_pop_b_push_c");
        drive(1'b0, '0, '0, '0);
        tick("bp_pop_c");
        chk("bp_drained_valid", 64'(valid), 64'(0));

        drive(1'b1, 32'h0000_0C22, 2'd2, 2'd2); tick("corner");
        drive(1'b0, '0, '0, '0);                tick("corner_drain");

        // Asynchronous reset with two flits queued.
        out_ready = 5'b00000;
        drive(1'b1, 32'h0000_0A01, 2'd0, 2'd1); tick("rst_fill_1");
        drive(1'b1, 32'h0000_0A02, 2'd2, 2'd0); tick("rst_fill_2");
        drive(1'b0, '0, '0, '0);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_outputs("async_reset");
        out_ready = 5'b11111;
        @(negedge clk);
        rst = 1'b1;
        tick("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_one_port.md
# router_one_port

Single-input, five-output mesh router stage for the 2-D synchronous NoC. It accepts flits on one input channel into a 2-entry FIFO. Each head flit is steered by dimension-order routing, comparing its destination with the router's own (X_COORD, Y_COORD), to exactly one of NORTH, EAST, SOUTH, WEST or LOCAL. It is the single-port building block from which the full five-port mesh router is assembled.

## Interface
- Direction index is fixed as NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4.
- CW is defined as $clog2(MESH_SIDE).
- Parameter `X_COORD`, default 0: router column.
- Parameter `Y_COORD`, default 0: router row.
- Parameter `DATA_WIDTH`, default 32: payload width.
- Parameter `MESH_SIDE`, default 3: mesh dimension.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_data`  in  DATA_WIDTH  input payload.
- `in_dest_x`, `in_dest_y`  in  CW each  destination coordinates.
- `in_s_delta_x`, `in_s_delta_y`  in  1 each  upstream sign bits; ignored, kept for interface compatibility.
- `in_valid`  in  1  input flit present.
- `in_ready`  out  1  FIFO can accept a flit.
- `out_data`  out  5×DATA_WIDTH  per-direction payload.
- `out_dest_x`, `out_dest_y`  out  5×CW each  forwarded destination.
- `out_s_delta_x`, `out_s_delta_y`  out  5 each  recomputed sign bits.
- `out_valid`  out  5  per-direction valid.
- `out_ready`  in  5  per-direction downstream ready.
- `valid`  out  1  FIFO non-empty (head flit present).
- `route_out_N`, `route_out_E`, `route_out_S`, `route_out_W`, `route_out_L`  out  1 each  one-hot decoded route of the head flit.

## Operation
- The FIFO is 2 entries deep and stores {data, dest_x, dest_y}.
- Push happens when `in_valid && in_ready`.
- `in_ready` = (count < 2). It is a function of registered count only, with no combinational path from `out_ready`.
- Routing is XY, computed from the head flit:
  - dest_x > X_COORD → EAST; dest_x < X_COORD → WEST.
  - Otherwise, dest_y > Y_COORD → SOUTH; dest_y < Y_COORD → NORTH.
  - Otherwise → LOCAL.
  - Comparisons are unsigned and CW bits wide.
- `route_out_*` is the one-hot route gated by `valid`; it is all-zero when the FIFO is empty.
- `out_valid[d]` = `valid && route==d`.
- Every direction's `out_data`, `out_dest_x` and `out_dest_y` show the head flit; consumers qualify with `out_valid`.
- `out_s_delta_x[d]` = (head dest_x < X_COORD); `out_s_delta_y[d]` = (head dest_y < Y_COORD). Both are the same for all d.
- Pop happens when `valid && out_ready[route]`.
- Push and pop may occur in the same cycle; count is then unchanged and order is preserved.
- FIFO pointers wrap modulo 2.
- Reset: count=0 and pointers=0. Consequently `in_ready`=1, and `valid`, `out_valid` and `route_out_*` are all 0. Stored data is don't-care and is not required to be reset.
- Asserting reset mid-operation discards all queued flits immediately (asynchronously).

## Timing
- Latency: a flit accepted at rising edge k appears on its output, with `out_valid` high, after edge k if the FIFO was empty.
- Throughput: 1 flit/cycle when the target `out_ready`=1.
- A blocked head holds all outputs stable until popped, with no head-of-line bypass.
- `in_ready` falls the cycle after the second unpopped push and rises the cycle after a pop.
- `out_valid` never depends combinationally on `out_ready`.

## Configuration
- Macro `ROUTER_ONE_PORT_YX_ROUTING_EN`.
- Defined: YX order. The Y comparison is resolved first (NORTH/SOUTH), then X (EAST/WEST), then LOCAL.
- Undefined (default): XY order as described above.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use X_COORD=1, Y_COORD=1, MESH_SIDE=3, all `out_ready`=1 unless stated.
- Destination routing, one flit each:
  - dest (2,1) → `route_out_E`=1, `out_valid`=5'b00010, s_delta=(0,0).
  - dest (0,0) → WEST, s_delta_x=1, s_delta_y=1.
  - dest (1,2) → SOUTH.
  - dest (1,0) → NORTH.
  - dest (1,1) → LOCAL.
- Streaming: send 10 flits with data 0x0A, 0x14, … and dest cycling (0..2, 0..2) back-to-back → one flit per cycle emerges in order with correct one-hot routes; `in_ready` stays 1.
- Backpressure: `out_ready[EAST]`=0, push three EAST flits → `in_ready`=0 after two are accepted. Raising `out_ready[EAST]` then drains them in order, and the third flit is then accepted.
- Corner route: dest (2,2) → EAST without the macro; SOUTH with `ROUTER_ONE_PORT_YX_ROUTING_EN` defined.
- Reset: assert `rst`=0 with 2 flits queued → `valid`, `out_valid` and `route_out_*` all drop immediately; `in_ready`=1 after release.
